// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory req/gnt/rvalid port plus the IF->ID handoff.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, stall, flush, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_gnt, imem_rvalid, imem_rdata, stall, flush, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited in-order fetch, response FIFO, flush/kill.
// Optional FETCH_BYPASS_EN presents a response straight to decode when the FIFO is empty.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIR} state_t;

  state_t        state, state_n;
  logic [31:0]   pc, pc_n;
  logic          req, req_n;
  logic [CW-1:0] outst, outst_n;
  logic [CW-1:0] kill, kill_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW:0]   used;
  logic [PW-1:0] wr_ptr, rd_ptr, aq_wr, aq_rd;
  entry_t        fifo [FIFO_DEPTH];
  logic [31:0]   aq   [FIFO_DEPTH];

  logic   run, grant, rsp, push, pop, valid_c;
  entry_t head, rsp_entry;

  assign run       = (state == S_RUN);
  assign grant     = req && bus.imem_gnt;
  assign rsp       = run && bus.imem_rvalid && !bus.flush;
  assign rsp_entry = {aq[aq_rd], bus.imem_rdata};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass  = rsp && (cnt == '0);
  assign valid_c = (run && !bus.flush && (cnt != '0)) || bypass;
  assign head    = (cnt == '0) ? rsp_entry : fifo[rd_ptr];
  assign pop     = valid_c && !bus.stall && (cnt != '0);
  assign push    = rsp && !(bypass && !bus.stall);
`else
  assign valid_c = run && !bus.flush && (cnt != '0);
  assign head    = fifo[rd_ptr];
  assign pop     = valid_c && !bus.stall;
  assign push    = rsp;
`endif

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = valid_c;
  assign bus.if_pc     = valid_c ? head.pc    : 32'h0;
  assign bus.if_instr  = valid_c ? head.instr : 32'h0;

  // Next state, PC, credit counters and request.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = 1'b0;
    outst_n = outst;
    kill_n  = kill;
    cnt_n   = cnt;
    used    = '0;

    case (state)
      S_BOOT:  state_n = S_RUN;
      S_RUN:   state_n = S_RUN;
      S_REDIR: if (kill == '0) state_n = S_RUN;
      default: state_n = S_BOOT;
    endcase

    if (bus.flush) begin
      // Everything in flight, including a grant this cycle, must be drained and dropped.
      state_n = S_REDIR;
      pc_n    = bus.redirect_pc & ~32'h3;
      outst_n = '0;
      cnt_n   = '0;
      kill_n  = kill + outst + CW'(grant) - CW'(bus.imem_rvalid);
    end else begin
      if (grant) pc_n = pc + 32'd4;

      if (grant && !rsp)      outst_n = outst + CW'(1);
      else if (rsp && !grant) outst_n = outst - CW'(1);

      if (push && !pop)      cnt_n = cnt + CW'(1);
      else if (pop && !push) cnt_n = cnt - CW'(1);

      if (state == S_REDIR && bus.imem_rvalid && kill != '0) kill_n = kill - CW'(1);

      used = {1'b0, outst_n} + {1'b0, cnt_n};
      if (req && !bus.imem_gnt) req_n = 1'b1;
      else                      req_n = (state_n == S_RUN) && (used < (CW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_BOOT;
      pc     <= RESET_PC;
      req    <= 1'b0;
      outst  <= '0;
      kill   <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      aq_wr  <= '0;
      aq_rd  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      req   <= req_n;
      outst <= outst_n;
      kill  <= kill_n;
      cnt   <= cnt_n;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        aq_wr  <= '0;
        aq_rd  <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + PW'(1);
        if (pop)   rd_ptr <= rd_ptr + PW'(1);
        if (grant) aq_wr  <= aq_wr + PW'(1);
        if (rsp)   aq_rd  <= aq_rd + PW'(1);
      end
    end
  end

  // Payload storage; the address queue pairs each response with its fetch PC.
  always_ff @(posedge clk) begin
    if (push)  fifo[wr_ptr] <= rsp_entry;
    if (grant) aq[aq_wr]    <= pc;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && cnt == CW'(FIFO_DEPTH)));
  end

endmodule
